// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the EX-stage M-extension multiply/divide unit.
package ex_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement negate when neg is set (magnitude extraction and sign fix-up).
  function automatic logic [XLEN-1:0] neg_fix(input logic [XLEN-1:0] v, input logic neg);
    return neg ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_div.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
// Exposes the post-step quotient/remainder so the parent can register the final value.
module ex_muldiv_div
  import ex_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // quo doubles as the dividend shift register; its MSB feeds the partial remainder.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
    if (diff[XLEN]) begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M multiply/divide unit: 32-cycle shift-add multiplier plus FSM.
// Division hardware is present only when EX_MULDIV_DIV_EN is defined.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3_e,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state;
  logic [CNT_W-1:0]  count;
  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] prod;

  logic              sgn_a, sgn_b, sa, sb, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_nxt, prod_fix;
  logic [XLEN-1:0]   mul_res, div_res, fin_res;
  logic              special;
  logic [XLEN-1:0]   special_res;

  // Operand sign decode and magnitudes at capture time.
  always_comb begin
    sgn_a  = (funct3_e != OP_MULHU) && (funct3_e != OP_DIVU) && (funct3_e != OP_REMU);
    sgn_b  = sgn_a && (funct3_e != OP_MULHSU);
    sa     = sgn_a & rs1_val[XLEN-1];
    sb     = sgn_b & rs2_val[XLEN-1];
    mag_a  = neg_fix(rs1_val, sa);
    mag_b  = neg_fix(rs2_val, sb);
    neg_in = (funct3_e == OP_REM) ? sa : (sa ^ sb);
  end

  // One shift-add step; prod holds {partial high, remaining multiplier bits}.
  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
    prod_nxt = {mul_sum, prod[XLEN-1:1]};
    prod_fix = neg ? (2*XLEN)'(-prod_nxt) : prod_nxt;
    mul_res  = (op == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    fin_res  = op[2] ? div_res : mul_res;
  end

`ifdef EX_MULDIV_DIV_EN
  logic            div_load, div_step, div_zero, div_ovf;
  logic [XLEN-1:0] quo_nxt, rem_nxt;

  assign div_load = (state == IDLE) & start & ~flush & funct3_e[2] & ~special;
  assign div_step = (state == BUSY) & ~flush & op[2];

  ex_muldiv_div u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  assign div_res = op[1] ? neg_fix(rem_nxt, neg) : neg_fix(quo_nxt, neg);

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    div_zero = (rs2_val == '0);
    div_ovf  = ~funct3_e[0] & (rs1_val == 32'h8000_0000) & (rs2_val == 32'hFFFF_FFFF);
    special  = funct3_e[2] & (div_zero | div_ovf);
    if (div_zero) special_res = funct3_e[1] ? rs1_val : 32'hFFFF_FFFF;
    else          special_res = funct3_e[1] ? 32'h0000_0000 : 32'h8000_0000;
  end
`else
  assign div_res     = '0;
  assign special     = funct3_e[2];
  assign special_res = '0;
`endif

  assign stall = ~rst & (((state == IDLE) & start & ~flush) | (state == BUSY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      op     <= '0;
      neg    <= 1'b0;
      mcand  <= '0;
      prod   <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done   <= 1'b0;
      result <= '0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            op    <= funct3_e;
            neg   <= neg_in;
            mcand <= mag_a;
            prod  <= {{XLEN{1'b0}}, mag_b};
            count <= '0;
            if (special) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= special_res;
            end else begin
              state <= BUSY;
            end
          end
          BUSY: begin
            prod  <= prod_nxt;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(XLEN-1)) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= fin_res;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: scoreboard of expected result/latency per op,
// independent 64-bit arithmetic model, flush and reset-mid-op scenarios.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3_e;
  logic [31:0] rs1_val, rs2_val;
  logic        stall, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];

  ex_muldiv dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3_e (funct3_e),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .flush    (flush),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    logic signed [63:0] sa64, sb64, ub64s;
    logic [63:0] ua64, ub64;
    sa64  = {{32{a[31]}}, a};
    sb64  = {{32{b[31]}}, b};
    ua64  = {32'h0, a};
    ub64  = {32'h0, b};
    ub64s = ub64;
    e.lat = 33;
    e.res = '0;
    p     = '0;
    case (f3)
      3'b000: begin p = ua64 * ub64;  e.res = p[31:0];  end
      3'b001: begin p = sa64 * sb64;  e.res = p[63:32]; end
      3'b010: begin p = sa64 * ub64s; e.res = p[63:32]; end
      3'b011: begin p = ua64 * ub64;  e.res = p[63:32]; end
      default: begin
`ifdef EX_MULDIV_DIV_EN
        if (b == 32'h0) begin
          e.lat = 1;
          e.res = f3[1] ? a : 32'hFFFF_FFFF;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lat = 1;
          e.res = f3[1] ? 32'h0 : 32'h8000_0000;
        end else begin
          case (f3)
            3'b100:  e.res = $signed(a) / $signed(b);
            3'b101:  e.res = a / b;
            3'b110:  e.res = $signed(a) % $signed(b);
            default: e.res = a % b;
          endcase
        end
`else
        e.lat = 1;
        e.res = 32'h0;
`endif
      end
    endcase
    return e;
  endfunction

  // Issue one op at the current (post-negedge) time and follow it to done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
    exp_t e;
    int   cyc;
    logic busy_ok;
    start    = 1'b1;
    funct3_e = f3;
    rs1_val  = a;
    rs2_val  = b;
    sb.push_back(model(f3, a, b));
    #1;
    check({tag, " stall_at_start"}, 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    rs1_val  = $urandom;
    rs2_val  = $urandom;
    funct3_e = 3'($urandom);
    cyc      = 1;
    busy_ok  = 1'b1;
    while (!done && cyc < 40) begin
      if (stall !== 1'b1 || result !== 32'h0) busy_ok = 1'b0;
      start = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " result"}, result, e.res);
    check({tag, " latency"}, 32'(cyc), 32'(e.lat));
    check({tag, " stall_in_done"}, 32'(stall), 32'd0);
    if (e.lat > 1) check({tag, " busy_stall_and_zero_result"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, " done_after"}, 32'(done), 32'd0);
    check({tag, " result_after"}, result, 32'h0);
    check({tag, " stall_after"}, 32'(stall), 32'd0);
  endtask

  initial begin
    $display("tb_ex_muldiv: M-extension funct7 %b", FUNCT7_MULDIV);
    rst      = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    funct3_e = 3'b000;
    rs1_val  = '0;
    rs2_val  = '0;
    repeat (2) @(negedge clk);
    check("reset stall", 32'(stall), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'h0);

    // First op issued on the very first edge after reset release.
    rst = 1'b0;
    run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, "MUL 7x-3");
    run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, "MULHU ffx ff");
    run_op(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, "MULH -1x-1");
    run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "MULHSU -1xff");
    run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000, "MULH min x min");
    run_op(OP_MUL,    32'h8000_0000,  32'hFFFF_FFFF, "MUL min x -1");
    run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         "DIV -7/2");
    run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         "REM -7/2");
    run_op(OP_DIV,    32'd7,          32'hFFFF_FFFE, "DIV 7/-2");
    run_op(OP_REM,    32'd7,          32'hFFFF_FFFE, "REM 7/-2");
    run_op(OP_DIVU,   32'd100,        32'd0,         "DIVU 100/0");
    run_op(OP_REM,    32'd5,          32'd0,         "REM 5/0");
    run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, "DIV ovf");
    run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, "REM ovf");
    run_op(OP_DIVU,   32'd100,        32'd7,         "DIVU 100/7");
    run_op(OP_REMU,   32'd100,        32'd7,         "REMU 100/7");
    run_op(OP_MUL,    32'd6,          32'd7,         "MUL 6x7");

    // Flush during iteration 10 aborts without a done pulse.
    start = 1'b1; funct3_e = OP_MUL; rs1_val = 32'd1234; rs2_val = 32'd5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush busy stall", 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush no done", 32'(done), 32'd0);
    check("flush idle stall", 32'(stall), 32'd0);
    check("flush result zero", result, 32'h0);
    run_op(OP_MULHU,  32'h1234_5678,  32'h9ABC_DEF0, "MULHU after flush");

    // Flush and start together in IDLE: no capture.
    start = 1'b1; flush = 1'b1; funct3_e = OP_MUL; rs1_val = 32'd3; rs2_val = 32'd3;
    #1;
    check("flush+start stall", 32'(stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush+start no capture", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush+start no done", 32'(done), 32'd0);
    end

    // Reset at iteration 5 clears outputs immediately, then first edge accepts a new op.
    start = 1'b1; funct3_e = OP_MUL; rs1_val = 32'd99; rs2_val = 32'd77;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("rst mid-op stall", 32'(stall), 32'd0);
    check("rst mid-op done", 32'(done), 32'd0);
    check("rst mid-op result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_MUL,    32'd99,         32'd77,        "MUL after rst");

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom);
      a  = $urandom;
      b  = (i == 2) ? 32'd13 : $urandom;
      run_op(f3, a, b, "random op");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port clk  in  1  single clock; all flops rise-edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  in  1  EX-stage M-extension op valid (funct7_e==7'b0000001, opcode OP).
REQ-004 SHALL have port funct3_e  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port rs1_val  in  32  forwarded operand A.
REQ-006 SHALL have port rs2_val  in  32  forwarded operand B.
REQ-007 SHALL have port flush  in  1  pipeline flush; aborts any op in progress.
REQ-008 SHALL have port stall  out  1  hold IF/ID/ID-EX while the op is not finished.
REQ-009 SHALL have port done  out  1  one-cycle pulse; result valid this cycle.
REQ-010 SHALL have port result  out  32  selected product half, quotient or remainder.

Function
REQ-011 SHALL implement states IDLE, BUSY, DONE.
REQ-012 IDLE with start=1 and flush=0 SHALL latch operands and funct3 at the edge, load count=0 and go to BUSY; special cases in REQ-016/017 go to DONE instead.
REQ-013 BUSY SHALL perform one radix-2 iteration per cycle (shift-add multiply or restoring divide on magnitudes), increment count, and go to DONE on the edge completing iteration 32 (count 31->wrap).
REQ-014 DONE SHALL assert done=1 for exactly one cycle, drive the final result, then go to IDLE unconditionally.
REQ-015 stall SHALL equal (IDLE & start & ~flush) | BUSY; stall=0 in DONE so the pipeline advances the same cycle; normal latency start-edge to done = 33 cycles.
REQ-016 Divide by zero SHALL go IDLE->DONE directly: DIV/DIVU quotient 32'hFFFF_FFFF, REM/REMU remainder = rs1_val.
REQ-017 DIV/REM with rs1=32'h8000_0000, rs2=32'hFFFF_FFFF SHALL go IDLE->DONE directly: quotient 32'h8000_0000, remainder 0.
REQ-018 Signed ops SHALL operate on magnitudes and correct sign at DONE: product sign = sA^sB (MULHSU: sA only); quotient sign = sA^sB; remainder sign = sA.
REQ-019 Product SHALL be 64-bit; MUL returns [31:0], MULH/MULHSU/MULHU return [63:32].
REQ-020 start in BUSY or DONE SHALL be ignored; operand changes after capture SHALL not affect the result.
REQ-021 flush=1 in any state SHALL force IDLE at the next edge with done=0; flush and start in the same IDLE cycle: flush wins, no capture.
REQ-022 result SHALL be 0 whenever done=0.

Reset
REQ-023 rst=1 SHALL asynchronously force state=IDLE, count=0, all datapath registers 0; stall=0, done=0, result=0 while asserted, including mid-op.
REQ-024 First op SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro EX_MULDIV_DIV_EN SHALL gate division hardware.
REQ-026 Defined: funct3[2]=1 ops SHALL behave per REQ-013..018.
REQ-027 Undefined: funct3[2]=1 ops SHALL go IDLE->DONE with result 0 (1-cycle stall, no divider logic); multiply ops unchanged.

Structure
REQ-028 Shared package SHALL hold XLEN=32, the muldiv_op enum (eight funct3 codes), the state enum and the M-extension funct7 constant.
REQ-029 Iterative divider SHALL be sub-module ex_muldiv_div (instantiated only under EX_MULDIV_DIV_EN); multiplier datapath and FSM stay in ex_muldiv.

Verification
REQ-030 MUL 7 x -3 -> done 33 cycles after start edge, result 32'hFFFF_FFEB, stall high cycles 0..32.
REQ-031 MULHU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> result 32'hFFFF_FFFE; MULH same operands -> 0.
REQ-032 DIV -7 / 2 -> 32'hFFFF_FFFD; REM -7 / 2 -> 32'hFFFF_FFFF; DIVU 100/0 -> 32'hFFFF_FFFF after 1-cycle stall.
REQ-033 DIV 32'h8000_0000 / -1 -> 32'h8000_0000, REM -> 0, both after 1-cycle stall.
REQ-034 flush at iteration 10 -> IDLE next edge, no done; new start next cycle -> correct result at +33; rst at iteration 5 -> outputs 0 immediately.
REQ-035 Build without EX_MULDIV_DIV_EN: DIVU 100/7 -> done after 1 cycle, result 0; MUL 6x7 -> 42.
